// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle execute-stage ALU.
// Holds the opcode encoding, the controller state set and the helper
// that separates iterative (MUL/DIVU/REMU) ops from single-cycle ops.
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_MUL  = 4'd3,
        ALU_DIVU = 4'd4,
        ALU_REMU = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // True for ops that run on the iterative shift/add-subtract engine.
    function automatic logic is_multicycle(input logic [OP_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: radix-2 shift-add multiply, restoring unsigned divide/remainder.
// Latency: WIDTH iterations after start; done pulses during the last one.
// Backpressure: none; start is only given while idle, result is captured by the parent.
//
// Ports: clk, rst_n (sync, active low); start loads a/b and the op kind
// (is_div, want_rem); done is combinational and high during the final
// iteration cycle, with res carrying that iteration's outcome.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             want_rem,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    logic             run_q;
    logic [SHW-1:0]   cnt_q;
    logic             div_q;
    logic             rem_sel_q;
    // acc_q: product accumulator (MUL) or partial remainder (DIV).
    // a_q:   shifting multiplicand (MUL) or dividend/quotient shift reg (DIV).
    // b_q:   shifting multiplier (MUL) or fixed divisor (DIV).
    logic [WIDTH-1:0] acc_q, a_q, b_q;
    logic [WIDTH-1:0] acc_d, a_d, b_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_diff;
    logic             take;

    always_comb begin
        rem_shift = {acc_q, a_q[WIDTH-1]};
        // Remainder stays below the divisor, so the difference always fits
        // in WIDTH bits and the borrow bit is not needed.
        rem_diff  = rem_shift[WIDTH-1:0] - b_q;
        take      = (rem_shift >= {1'b0, b_q});
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        if (div_q) begin
            // Divisor 0 makes every step "take": quotient all ones,
            // remainder ends up equal to the dividend.
            acc_d = take ? rem_diff : rem_shift[WIDTH-1:0];
            a_d   = {a_q[WIDTH-2:0], take};
        end else begin
            acc_d = acc_q + (b_q[0] ? a_q : '0);
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
        end
    end

    assign done = run_q && (cnt_q == '0);
    assign res  = (div_q && !rem_sel_q) ? a_d : acc_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            rem_sel_q <= 1'b0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else if (start) begin
            run_q     <= 1'b1;
            cnt_q     <= SHW'(WIDTH - 1);
            div_q     <= is_div;
            rem_sel_q <= want_rem;
            acc_q     <= '0;
            a_q       <= a;
            b_q       <= b;
        end else if (run_q) begin
            acc_q <= acc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_q - SHW'(1);
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU behind valid/ready on both sides.
// Latency: 1 cycle for simple ops, WIDTH+1 cycles for MUL/DIVU/REMU.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
//
// Ports: clk, rst_n (sync, active low); request side in_valid/in_ready with
// alu_op, op1, op2 sampled on accept; response side out_valid/out_ready with
// registered result; busy mirrors the BUSY state.
module alu_mc
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] result_q;

    logic             accept;
    logic             long_op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] simple_res_d;
    logic             mdu_done;
    logic [WIDTH-1:0] mdu_res;

    assign accept  = in_valid && in_ready_q;
    assign long_op = is_multicycle(alu_op);
    assign shamt   = op2[SHW-1:0];

    // Single-cycle datapath; evaluated on the raw inputs and captured at accept.
    always_comb begin
        simple_res_d = '0;
        case (alu_op)
            ALU_ADD: simple_res_d = op1 + op2;
            ALU_SUB: simple_res_d = op1 - op2;
            ALU_SLL: simple_res_d = op1 << shamt;
            ALU_SRL: simple_res_d = op1 >> shamt;
            ALU_SRA: simple_res_d = $signed(op1) >>> shamt;
            ALU_SLT: simple_res_d = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            default: simple_res_d = '0;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept && long_op),
        .is_div   (alu_op != ALU_MUL),
        .want_rem (alu_op == ALU_REMU),
        .a        (op1),
        .b        (op2),
        .done     (mdu_done),
        .res      (mdu_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (long_op) begin
                            state_q <= BUSY;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= simple_res_d;
                        end
                    end
                end
                BUSY: begin
                    // Final iteration and transition share the same edge.
                    if (mdu_done) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        result_q    <= mdu_res;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0]  alu_op;
    logic [31:0] op1, op2, result;

    logic        in_valid16, in_ready16, out_valid16, busy16;
    logic [3:0]  alu_op16;
    logic [15:0] op1_16, op2_16, result16;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .op1(op1), .op2(op2), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    alu_mc #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .alu_op(alu_op16), .op1(op1_16), .op2(op2_16), .out_valid(out_valid16),
        .out_ready(1'b1), .result(result16), .busy(busy16)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          lat;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, id, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on the 32-bit DUT with out_ready high and check latency/result.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input int id);
        int  k;
        bit  bad;
        k = 0;
        while (!in_ready && k < 100) begin step(); k++; end
        chk("ready_before", id, 32'(in_ready), 32'd1);
        alu_op = op; op1 = a; op2 = b; in_valid = 1'b1;
        step();
        // Post-accept input changes must be ignored.
        in_valid = 1'b0; op1 = 32'hDEAD_BEEF; op2 = 32'h3; alu_op = 4'd2;
        k = 0; bad = 0;
        while (!out_valid && k < 100) begin
            if (!busy || in_ready) bad = 1;
            step();
            k++;
        end
        chk("latency", id, 32'(k + 1), 32'(exp_lat));
        chk("result", id, result, exp_res);
        if (exp_lat > 1) chk("busy_hold", id, 32'(bad), 32'd0);
        step();
        chk("ready_after", id, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_res, input int id);
        int k;
        alu_op16 = 4'd3; op1_16 = a; op2_16 = b; in_valid16 = 1'b1;
        step();
        in_valid16 = 1'b0; op1_16 = 16'h5555;
        k = 0;
        while (!out_valid16 && k < 100) begin step(); k++; end
        chk("lat16", id, 32'(k + 1), 32'd17);
        chk("res16", id, {16'd0, result16}, {16'd0, exp_res});
        step();
        chk("ready16", id, 32'(in_ready16), 32'd1);
    endtask

    initial begin
        int  k;
        bit  seen;

        vecs[0]  = '{4'd1, 32'hFFFF_FFFF, 32'h1,          32'h0000_0000, 1};
        vecs[1]  = '{4'd2, 32'd3,         32'd5,          32'hFFFF_FFFE, 1};
        vecs[2]  = '{4'd8, 32'hFFFF_FFFF, 32'd1,          32'd1,         1};
        vecs[3]  = '{4'd8, 32'd1,         32'hFFFF_FFFF,  32'd0,         1};
        vecs[4]  = '{4'd9, 32'h8000_0000, 32'd4,          32'hF800_0000, 1};
        vecs[5]  = '{4'd6, 32'd1,         32'h25,         32'h20,        1};
        vecs[6]  = '{4'd7, 32'h8000_0000, 32'h25,         32'h0400_0000, 1};
        vecs[7]  = '{4'd9, 32'h8000_0000, 32'h1F,         32'hFFFF_FFFF, 1};
        vecs[8]  = '{4'd9, 32'h7FFF_FFFF, 32'h1F,         32'h0,         1};
        vecs[9]  = '{4'd15, 32'd12,       32'd34,         32'h0,         1};
        vecs[10] = '{4'd0, 32'd12,        32'd34,         32'h0,         1};
        vecs[11] = '{4'd3, 32'h1234_5678, 32'h10,         32'h2345_6780, 33};
        vecs[12] = '{4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0000_0001, 33};
        vecs[13] = '{4'd4, 32'd100,       32'd7,          32'd14,        33};
        vecs[14] = '{4'd5, 32'd100,       32'd7,          32'd2,         33};
        vecs[15] = '{4'd4, 32'd5,         32'd0,          32'hFFFF_FFFF, 33};
        vecs[16] = '{4'd5, 32'd5,         32'd0,          32'd5,         33};
        vecs[17] = '{4'd4, 32'hFFFF_FFFF, 32'd10,         32'h1999_9999, 33};
        vecs[18] = '{4'd5, 32'hFFFF_FFFF, 32'd10,         32'd5,         33};
        vecs[19] = '{4'd1, 32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 4'd0; op1 = '0; op2 = '0;
        in_valid16 = 1'b0; alu_op16 = 4'd0; op1_16 = '0; op2_16 = '0;
        step(); step();
        chk("rst_state", 0, {28'd0, in_ready, out_valid, busy, 1'b0}, 32'b1000);
        chk("rst_result", 0, result, 32'd0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].lat, i);

        // Backpressure: hold the ADD result for 10 cycles.
        out_ready = 1'b0;
        alu_op = 4'd1; op1 = 32'd2; op2 = 32'd2; in_valid = 1'b1;
        step();
        op1 = 32'd99;  // request kept asserted with new data; must not be taken
        for (int c = 0; c < 10; c++) begin
            chk("bp_flags", c, {29'd0, out_valid, in_ready, busy}, 32'b100);
            chk("bp_result", c, result, 32'd4);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release", 0, {30'd0, in_ready, out_valid}, 32'b10);
        step();
        chk("bp_no_new", 0, 32'(out_valid), 32'd0);

        // Reset during BUSY aborts the op.
        alu_op = 4'd3; op1 = 32'd7; op2 = 32'd9; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) step();
        chk("pre_rst_busy", 0, 32'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_state", 0, {28'd0, in_ready, out_valid, busy, 1'b0}, 32'b1000);
        chk("mid_rst_result", 0, result, 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) seen = 1;
            step();
        end
        chk("no_stale_result", 0, 32'(seen), 32'd0);
        run_op(4'd3, 32'd7, 32'd9, 32'd63, 33, 100);

        // Parametrisation check at WIDTH=16.
        run16(16'h1234, 16'h0010, 16'h2340, 0);
        run16(16'hFFFF, 16'hFFFF, 16'h0001, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time bound so the run cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1);
    end

endmodule
